// File: rtl/sysarr_sparse_fifo.sv
// Sparse-row FIFO for a systolic array feeder.
// Each entry holds a nonzero value, its column index, and an end-of-row flag.
// The head entry is shown ahead on rd_* outputs. A row counter lets a consumer
// see when a complete row is buffered. Overflow and underflow are sticky.
module sysarr_sparse_fifo #(
    parameter int DW    = 16,
    parameter int IW    = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_val,
    input  logic [IW-1:0]              wr_ind,
    input  logic                       wr_end,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_val,
    output logic [IW-1:0]              rd_ind,
    output logic                       rd_end,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     rows,
    output logic                       row_avail,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Storage is data only; it is never reset and is gated at the outputs.
    logic [DW-1:0] r_val_mem [DEPTH];
    logic [IW-1:0] r_ind_mem [DEPTH];
    logic          r_end_mem [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_rows;
    logic          r_overflow;
    logic          r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_evt;
    logic w_udf_evt;
    logic w_head_end;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_head_end = r_end_mem[r_rptr];

    // Flush overrides everything: no acceptance and no error events that cycle.
    assign w_rd_acc  = ~flush & rd_en & ~w_empty;
    assign w_wr_acc  = ~flush & wr_en & (~w_full | w_rd_acc);
    assign w_ovf_evt = ~flush & wr_en & ~w_wr_acc;
    assign w_udf_evt = ~flush & rd_en & w_empty;

    // Write accepted entries into storage at the write pointer.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_val_mem[r_wptr] <= wr_val;
            r_ind_mem[r_wptr] <= wr_ind;
            r_end_mem[r_wptr] <= wr_end;
        end
    end

    // Pointers and occupancy counters; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rows  <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rows  <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            if (w_rd_acc) r_rptr <= r_rptr + AW'(1);

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case ({w_wr_acc & wr_end, w_rd_acc & w_head_end})
                2'b10:   r_rows <= r_rows + CW'(1);
                2'b01:   r_rows <= r_rows - CW'(1);
                default: r_rows <= r_rows;
            endcase
        end
    end

    // Sticky error flags; a new event in the clear cycle wins over the clear.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= w_ovf_evt;
            r_underflow <= w_udf_evt;
        end else begin
            r_overflow  <= r_overflow  | w_ovf_evt;
            r_underflow <= r_underflow | w_udf_evt;
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign count     = r_count;
    assign rows      = r_rows;
    assign row_avail = (r_rows != '0);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    // Head entry is zeroed while empty so stale storage never leaks out.
    assign rd_val = w_empty ? '0   : r_val_mem[r_rptr];
    assign rd_ind = w_empty ? '0   : r_ind_mem[r_rptr];
    assign rd_end = w_empty ? 1'b0 : w_head_end;

endmodule

// File: tb/tb_sysarr_sparse_fifo.sv
// Directed testbench for sysarr_sparse_fifo (DW=8, IW=4, DEPTH=4).
module tb_sysarr_sparse_fifo;

    localparam int DW    = 8;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          nRST;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_val;
    logic [IW-1:0] wr_ind;
    logic          wr_end;
    logic          full;
    logic          rd_en;
    logic [DW-1:0] rd_val;
    logic [IW-1:0] rd_ind;
    logic          rd_end;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] rows;
    logic          row_avail;
    logic          overflow;
    logic          underflow;
    logic          err_clr;

    int n_checks;
    int n_errors;

    sysarr_sparse_fifo #(.DW(DW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_val    (wr_val),
        .wr_ind    (wr_ind),
        .wr_end    (wr_end),
        .full      (full),
        .rd_en     (rd_en),
        .rd_val    (rd_val),
        .rd_ind    (rd_ind),
        .rd_end    (rd_end),
        .empty     (empty),
        .count     (count),
        .rows      (rows),
        .row_avail (row_avail),
        .overflow  (overflow),
        .underflow (underflow),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v, input logic [IW-1:0] i, input logic e);
        wr_en  = 1'b1;
        wr_val = v;
        wr_ind = i;
        wr_end = e;
        tick();
        wr_en  = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        nRST    = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        wr_val  = '0;
        wr_ind  = '0;
        wr_end  = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;

        // Reset state
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rows", 32'(rows), 32'd0);
        chk("rst_row_avail", 32'(row_avail), 32'd0);
        chk("rst_rd_val", 32'(rd_val), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
        #10;
        nRST = 1'b1;
        tick();

        // Fill / overflow / drain
        push(8'h11, 4'd1, 1'b0);
        chk("fill1_rd_val", 32'(rd_val), 32'h11);
        chk("fill1_rd_ind", 32'(rd_ind), 32'd1);
        push(8'h22, 4'd3, 1'b1);
        push(8'h33, 4'd0, 1'b0);
        push(8'h44, 4'd2, 1'b1);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_rows", 32'(rows), 32'd2);
        chk("fill_ovf_pre", 32'(overflow), 32'd0);
        push(8'h55, 4'd5, 1'b1);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_rows", 32'(rows), 32'd2);
        chk("drain0", 32'(rd_val), 32'h11);
        pop();
        chk("drain1", 32'(rd_val), 32'h22);
        chk("drain1_end", 32'(rd_end), 32'd1);
        pop();
        chk("drain2", 32'(rd_val), 32'h33);
        chk("drain2_rows", 32'(rows), 32'd1);
        pop();
        chk("drain3", 32'(rd_val), 32'h44);
        pop();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_rd_val", 32'(rd_val), 32'd0);
        chk("drain_rd_ind", 32'(rd_ind), 32'd0);
        chk("drain_rd_end", 32'(rd_end), 32'd0);
        chk("drain_rows", 32'(rows), 32'd0);
        chk("drain_udf", 32'(underflow), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Wrap-around through six write/pop pairs
        for (int k = 1; k <= 6; k++) begin
            push(8'(k), 4'(k), 1'b1);
            chk($sformatf("wrap%0d_val", k), 32'(rd_val), 32'(k));
            chk($sformatf("wrap%0d_cnt", k), 32'(count), 32'd1);
            chk($sformatf("wrap%0d_ravail", k), 32'(row_avail), 32'd1);
            pop();
            chk($sformatf("wrap%0d_cnt0", k), 32'(count), 32'd0);
        end

        // Full concurrent write and pop
        push(8'hA0, 4'd0, 1'b1);
        push(8'hA1, 4'd1, 1'b0);
        push(8'hA2, 4'd2, 1'b1);
        push(8'hA3, 4'd3, 1'b0);
        chk("cc_rows_pre", 32'(rows), 32'd2);
        chk("cc_head", 32'(rd_val), 32'hA0);
        rd_en = 1'b1;
        push(8'hB0, 4'd1, 1'b0);
        rd_en = 1'b0;
        chk("cc_count", 32'(count), 32'd4);
        chk("cc_full", 32'(full), 32'd1);
        chk("cc_rows", 32'(rows), 32'd1);
        chk("cc_ovf", 32'(overflow), 32'd0);
        chk("cc_head2", 32'(rd_val), 32'hA1);
        pop();
        pop();
        pop();
        chk("cc_tail_val", 32'(rd_val), 32'hB0);
        chk("cc_tail_ind", 32'(rd_ind), 32'd1);
        chk("cc_tail_end", 32'(rd_end), 32'd0);
        chk("cc_tail_rows", 32'(rows), 32'd0);
        pop();
        chk("cc_empty", 32'(empty), 32'd1);

        // Empty-side cases
        pop();
        chk("udf_set", 32'(underflow), 32'd1);
        chk("udf_count", 32'(count), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", 32'(underflow), 32'd0);
        rd_en = 1'b1;
        push(8'h7F, 4'd9, 1'b1);
        rd_en = 1'b0;
        chk("rw_empty_count", 32'(count), 32'd1);
        chk("rw_empty_val", 32'(rd_val), 32'h7F);
        chk("rw_empty_ind", 32'(rd_ind), 32'd9);
        chk("rw_empty_ravail", 32'(row_avail), 32'd1);
        chk("rw_empty_udf", 32'(underflow), 32'd1);
        pop();
        chk("rw_pop_rows", 32'(rows), 32'd0);
        err_clr = 1'b1;
        rd_en   = 1'b1;
        tick();
        err_clr = 1'b0;
        rd_en   = 1'b0;
        chk("clr_vs_evt", 32'(underflow), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr2", 32'(underflow), 32'd0);

        // Flush with concurrent requests
        push(8'hC1, 4'd1, 1'b0);
        push(8'hC2, 4'd2, 1'b1);
        push(8'hC3, 4'd3, 1'b0);
        chk("fl_pre_count", 32'(count), 32'd3);
        chk("fl_pre_rows", 32'(rows), 32'd1);
        flush = 1'b1;
        rd_en = 1'b1;
        push(8'hC4, 4'd4, 1'b1);
        flush = 1'b0;
        rd_en = 1'b0;
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_rows", 32'(rows), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_rd_val", 32'(rd_val), 32'd0);
        chk("fl_ovf", 32'(overflow), 32'd0);
        chk("fl_udf", 32'(underflow), 32'd0);
        push(8'hF1, 4'd7, 1'b0);
        chk("fl_after_val", 32'(rd_val), 32'hF1);

        // Asynchronous reset mid-operation
        push(8'hD2, 4'd5, 1'b1);
        chk("rs_pre_count", 32'(count), 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("rs_count", 32'(count), 32'd0);
        chk("rs_empty", 32'(empty), 32'd1);
        chk("rs_rows", 32'(rows), 32'd0);
        chk("rs_rd_val", 32'(rd_val), 32'd0);
        chk("rs_rd_ind", 32'(rd_ind), 32'd0);
        @(negedge clk);
        @(negedge clk);
        nRST = 1'b1;
        push(8'hE1, 4'd6, 1'b1);
        chk("rs_first_val", 32'(rd_val), 32'hE1);
        chk("rs_first_count", 32'(count), 32'd1);
        push(8'hE2, 4'd7, 1'b0);
        push(8'hE3, 4'd8, 1'b0);
        push(8'hE4, 4'd9, 1'b1);
        chk("rs_refill_full", 32'(full), 32'd1);
        chk("rs_refill_ovf", 32'(overflow), 32'd0);
        chk("rs_refill_head", 32'(rd_val), 32'hE1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysarr_sparse_fifo.md
SYSARR_SPARSE_FIFO -- requirements
Module: sysarr_sparse_fifo

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DW, 16, value width.
- IW, 4, column-index width.
- DEPTH, 8, entry count; a power of two, at least 2.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning). CW = $clog2(DEPTH)+1.
- clk, in, 1, clock; one clock only, all state on its rising edge.
- nRST, in, 1, reset; asynchronous, active-low.
- flush, in, 1, synchronous discard of all contents.
- wr_en, in, 1, write request.
- wr_val, in, DW, nonzero value.
- wr_ind, in, IW, column index.
- wr_end, in, 1, last entry of a sparse row.
- full, out, 1, FIFO holds DEPTH entries.
- rd_en, in, 1, pop request.
- rd_val, out, DW, head value.
- rd_ind, out, IW, head index.
- rd_end, out, 1, head end flag.
- empty, out, 1, FIFO holds 0 entries.
- count, out, CW, entries held.
- rows, out, CW, complete rows held, i.e. entries with end=1.
- row_avail, out, 1, rows != 0.
- overflow, out, 1, sticky: write refused.
- underflow, out, 1, sticky: read refused.
- err_clr, in, 1, clears the sticky flags.

Function
REQ-003 The block SHALL store (val, ind, end) triples in a circular buffer of DEPTH entries, addressed by read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-004 rd_val/rd_ind/rd_end SHALL be show-ahead, giving the head entry combinationally from registered storage, and SHALL be all-zero while empty=1.
REQ-005 A read SHALL be accepted iff rd_en=1 and empty=0; the read pointer then advances by 1.
REQ-006 A write SHALL be accepted iff wr_en=1 and (full=0 or a read is accepted in the same cycle).
- The entry is stored at the write pointer, and the pointer advances by 1.
REQ-007 A write to an empty FIFO SHALL appear on rd_* exactly one cycle after acceptance; there is no same-cycle bypass.
REQ-008 count SHALL update the cycle after acceptance:
- +1 for write only.
- -1 for read only.
- Unchanged for simultaneous write+read.
- It never exceeds DEPTH and never goes below 0.
REQ-009 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both derived from registered state.
REQ-010 rows SHALL update the cycle after acceptance: +1 for an accepted write with wr_end=1, -1 for an accepted read with rd_end=1; both in the same cycle leave it unchanged.
REQ-011 row_avail SHALL be 1 whenever rows != 0, so a consumer may pop a whole row without stalling mid-row.
REQ-012 overflow SHALL set on the cycle after a refused write (wr_en=1 with no write accepted); underflow SHALL set on the cycle after a refused read (rd_en=1, empty=1).
REQ-013 The sticky flags SHALL clear on err_clr=1; if a new error event coincides with err_clr, the flag SHALL end set.
REQ-014 flush=1 SHALL have highest priority:
- The next cycle has pointers, count and rows at 0, and empty=1.
- wr_en and rd_en in the flush cycle are ignored and raise no error flags.
- Storage contents need not be cleared.
- The sticky flags are unaffected.
REQ-015 Simultaneous read and write on a full FIFO SHALL complete both, leaving count=DEPTH and rows adjusted per REQ-010.
REQ-016 Simultaneous rd_en and wr_en on an empty FIFO SHALL accept only the write and set underflow.

Reset
REQ-017 While nRST=0, the block SHALL immediately force: pointers=0, count=0, rows=0, empty=1, full=0, row_avail=0, rd_*=0, overflow=0, underflow=0.
REQ-018 Storage contents need not be reset; outputs depend on REQ-004 gating.
REQ-019 Assertion of nRST mid-operation SHALL discard all entries.
REQ-020 The first write after nRST deasserts SHALL land at entry 0.

Verification (DW=8, IW=4, DEPTH=4)
REQ-021 Fill/drain: write (0x11,1,0),(0x22,3,1),(0x33,0,0),(0x44,2,1), then hold wr_en=1 with (0x55,5,1).
- Expected: full=1, count=4, rows=2, overflow=1 next cycle, 0x55 lost.
- Then pop 4 entries: rd_val sequence 0x11,0x22,0x33,0x44, then empty=1, rd_*=0.
REQ-022 Wrap-around: perform 6 write/pop pairs with incrementing values starting 0x01.
- Expected: outputs in order 0x01..0x06 with count never above 1, confirming pointer wrap.
REQ-023 Full concurrent write and pop: FIFO full with head (0xA0,0,1); write (0xB0,1,0) while popping.
- Expected: count stays 4, rows decreases by 1, new tail is 0xB0.
REQ-024 Empty-side cases:
- rd_en on empty sets underflow with count unchanged.
- rd_en+wr_en of (0x7F,9,1) on empty gives count=1, rd_val=0x7F, row_avail=1 one cycle later.
- err_clr then clears underflow.
REQ-025 Flush and reset:
- 3 entries loaded, then flush together with wr_en and rd_en: next cycle count=0, rows=0, empty=1, no flag change.
- Then load 2 entries, pulse nRST low mid-cycle: outputs zero immediately; next write appears from entry 0.
